mem_rd_stream_port: RTL and testbench

Read-side client for the team's simple dual-port RAM (one synchronous write port, one registered read port with one cycle of latency, old data returned on a same-address read/write collision). The block turns that raw port into a valid/ready request/response stream with in-order responses. It applies write-first forwarding, so a read accepted in the same cycle as a write to the same address returns the new data. It also provides a response buffer, so the consumer can stall without losing data. It sits between a pipeline stage that issues read addresses and the RAM instance.

---
 rtl/mem_rd_stream_port.sv | 120 ++++++++++++
 tb/tb_mem_rd_stream_port.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_stream_port.sv
// Read-side stream client for a simple dual-port RAM: valid/ready requests,
// write-first forwarding on same-edge collisions, in-order buffered responses.
module mem_rd_stream_port #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  output logic [ADDR_WIDTH-1:0]         ram_rdaddress,
  input  logic [DATA_WIDTH-1:0]         ram_q,
  input  logic                          wr_en,
  input  logic [ADDR_WIDTH-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [$clog2(DEPTH+1):0]      occupancy,
  output logic [15:0]                   bypass_count
);

  localparam int OCC_W = $clog2(DEPTH + 1) + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                  inflight_q, inflight_d;
  logic                  fwd_q, fwd_d;
  logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [15:0]           bypass_q, bypass_d;
  logic [DATA_WIDTH-1:0] buf_q [DEPTH];

  logic                  accept_s;
  logic                  pop_s;
  logic                  push_s;
  logic                  hit_s;
  logic [OCC_W-1:0]      occ_s;
  logic [DATA_WIDTH-1:0] push_data_s;

  assign ram_rdaddress = req_addr;
  assign rsp_valid     = (count_q != {CNT_W{1'b0}});
  assign rsp_data      = buf_q[rd_ptr_q];
  assign occ_s         = OCC_W'(count_q) + OCC_W'(inflight_q);
  assign occupancy     = occ_s;
  assign bypass_count  = bypass_q;

  assign pop_s       = rsp_valid && rsp_ready;
  assign push_s      = inflight_q;
  assign push_data_s = fwd_q ? fwd_data_q : ram_q;
  // Room check counts the response still in the RAM pipeline and credits a same-cycle pop.
  assign req_ready   = !reset && ((occ_s - OCC_W'(pop_s)) < OCC_W'(DEPTH));
  assign accept_s    = req_valid && req_ready;
  assign hit_s       = wr_en && (wr_addr == req_addr);

  always_comb begin
    inflight_d = accept_s;
    fwd_d      = accept_s && hit_s;
    fwd_data_d = fwd_data_q;
    if (accept_s && hit_s) begin
      fwd_data_d = wr_data;
    end else begin
      fwd_data_d = fwd_data_q;
    end

    count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

    rd_ptr_d = rd_ptr_q;
    if (pop_s) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    wr_ptr_d = wr_ptr_q;
    if (push_s) begin
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    bypass_d = bypass_q;
    if (accept_s && hit_s && (bypass_q != 16'hFFFF)) begin
      bypass_d = bypass_q + 16'd1;
    end else begin
      bypass_d = bypass_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inflight_q <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_data_q <= {DATA_WIDTH{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      bypass_q   <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      inflight_q <= inflight_d;
      fwd_q      <= fwd_d;
      fwd_data_q <= fwd_data_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      bypass_q   <= bypass_d;
      if (push_s) begin
        buf_q[wr_ptr_q] <= push_data_s;
      end
    end
  end

endmodule

// File: tb/tb_mem_rd_stream_port.sv
// Self-checking bench: behavioural RAM plus a queue-based reference of
// expected responses derived from the write-first/in-order rules.
module tb_mem_rd_stream_port;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int DEPTH = 2;
  localparam int OW = $clog2(DEPTH + 1) + 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [AW-1:0] ram_rdaddress;
  logic [DW-1:0] ram_q;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [OW-1:0] occupancy;
  logic [15:0]   bypass_count;

  logic [DW-1:0] ram [16];
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] exp_q [$];
  int bypass_model = 0;
  int pops_seen = 0;
  int checks = 0;
  int errors = 0;

  mem_rd_stream_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .ram_rdaddress(ram_rdaddress), .ram_q(ram_q),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .occupancy(occupancy), .bypass_count(bypass_count)
  );

  always #5 clock = ~clock;

  // RAM: registered read returns old data on a same-address collision.
  always @(posedge clock) begin
    if (wr_en) ram[wr_addr] <= wr_data;
    ram_q <= ram[ram_rdaddress];
  end

  // One clock cycle: observe handshakes before the edge, update the reference, advance.
  task automatic step(output bit acc);
    bit pp;
    logic [DW-1:0] e;
    @(negedge clock);
    acc = req_valid && req_ready;
    pp = rsp_valid && rsp_ready;
    if (pp) begin
      checks++;
      pops_seen++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got %h, expected no response", rsp_data);
      end else begin
        e = exp_q.pop_front();
        if (rsp_data !== e) begin
          errors++;
          $display("FAIL rsp_data: got %h, expected %h", rsp_data, e);
        end
      end
    end
    if (acc) begin
      if (wr_en && wr_addr == req_addr) begin
        exp_q.push_back(wr_data);
        if (bypass_model < 65535) bypass_model++;
      end else begin
        exp_q.push_back(model_mem[req_addr]);
      end
    end
    if (wr_en) model_mem[wr_addr] = wr_data;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    req_valid = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'(i + 16'h10);
      model_mem[i] = 8'(i + 16'h10);
    end
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || occupancy !== '0 ||
        bypass_count !== 16'h0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_values: valid=%b data=%h occ=%0d byp=%0d rdy=%b, expected 0 0 0 0 0",
               rsp_valid, rsp_data, occupancy, bypass_count, req_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_stream;
    bit a;
    int p0;
    rsp_ready = 1'b1;
    p0 = pops_seen;
    req_valid = 1'b1;
    req_addr = 4'd0;
    step(a);
    checks++;
    if (rsp_valid !== 1'b0 || occupancy !== OW'(1)) begin
      errors++;
      $display("FAIL stream_first_edge: valid=%b occ=%0d, expected 0 1", rsp_valid, occupancy);
    end
    req_addr = 4'd1;
    step(a);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h10) begin
      errors++;
      $display("FAIL stream_latency: valid=%b data=%h, expected 1 10", rsp_valid, rsp_data);
    end
    req_addr = 4'd2;
    step(a);
    req_addr = 4'd3;
    step(a);
    idle(2);
    checks++;
    if (pops_seen - p0 != 4 || occupancy !== '0) begin
      errors++;
      $display("FAIL stream_throughput: pops=%0d occ=%0d, expected 4 0", pops_seen - p0, occupancy);
    end
  endtask

  task automatic test_late_write;
    bit a;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 4'd5;
    step(a);
    req_valid = 1'b0;
    wr_en = 1'b1;
    wr_addr = 4'd5;
    wr_data = 8'hBB;
    step(a);
    wr_en = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h15) begin
      errors++;
      $display("FAIL late_write: valid=%b data=%h, expected 1 15", rsp_valid, rsp_data);
    end
    idle(2);
  endtask

  task automatic test_collision;
    bit a;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr = 4'd5;
    wr_en = 1'b1;
    wr_addr = 4'd5;
    wr_data = 8'hAA;
    step(a);
    req_valid = 1'b0;
    wr_en = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL collision_early: valid=%b, expected 0", rsp_valid);
    end
    step(a);
    checks++;
    if (rsp_data !== 8'hAA || bypass_count !== 16'd1) begin
      errors++;
      $display("FAIL collision: data=%h byp=%0d, expected aa 1", rsp_data, bypass_count);
    end
    idle(2);
  endtask

  task automatic test_backpressure;
    bit a;
    int idx = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = (idx < 3);
      req_addr = 4'(7 + idx);
      step(a);
      if (a) idx++;
    end
    checks++;
    if (idx != 2 || req_ready !== 1'b0 || occupancy !== OW'(2)) begin
      errors++;
      $display("FAIL backpressure: accepts=%0d rdy=%b occ=%0d, expected 2 0 2", idx, req_ready, occupancy);
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req_valid = (idx < 3);
      req_addr = 4'(7 + idx);
      step(a);
      if (a) idx++;
    end
    checks++;
    if (idx != 3 || exp_q.size() != 0 || occupancy !== '0) begin
      errors++;
      $display("FAIL backpressure_drain: accepts=%0d left=%0d occ=%0d, expected 3 0 0",
               idx, exp_q.size(), occupancy);
    end
  endtask

  task automatic test_alternating;
    bit a;
    int p0 = pops_seen;
    int bad_occ = 0;
    for (int i = 0; i < 48; i++) begin
      rsp_ready = (i % 2 == 0);
      req_valid = 1'b1;
      req_addr = 4'($urandom_range(0, 15));
      wr_en = ($urandom_range(0, 2) == 0);
      wr_addr = ($urandom_range(0, 1) == 0) ? req_addr : 4'($urandom_range(0, 15));
      wr_data = 8'($urandom_range(0, 255));
      step(a);
      if (occupancy > OW'(DEPTH)) bad_occ++;
    end
    rsp_ready = 1'b1;
    idle(4);
    checks++;
    if (bad_occ != 0 || exp_q.size() != 0 || pops_seen - p0 < 8) begin
      errors++;
      $display("FAIL alternating: occ_over=%0d left=%0d pops=%0d, expected 0 0 >=8",
               bad_occ, exp_q.size(), pops_seen - p0);
    end
  endtask

  task automatic test_async_reset;
    bit a;
    rsp_ready = 1'b0;
    req_valid = 1'b1;
    req_addr = 4'd3;
    step(a);
    step(a);
    step(a);
    checks++;
    if (occupancy !== OW'(2)) begin
      errors++;
      $display("FAIL pre_reset_occ: occ=%0d, expected 2", occupancy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || occupancy !== '0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b occ=%0d rdy=%b, expected 0 0 0", rsp_valid, occupancy, req_ready);
    end
    exp_q.delete();
    bypass_model = 0;
    req_valid = 1'b0;
    step(a);
    reset = 1'b0;
    req_valid = 1'b1;
    req_addr = 4'd0;
    rsp_ready = 1'b1;
    step(a);
    req_valid = 1'b0;
    step(a);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== model_mem[0]) begin
      errors++;
      $display("FAIL post_reset_read: valid=%b data=%h, expected 1 %h", rsp_valid, rsp_data, model_mem[0]);
    end
    idle(2);
  endtask

  task automatic test_bypass_saturation;
    bit a;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    wr_en = 1'b1;
    for (int i = 0; i < 70000; i++) begin
      req_addr = 4'(i);
      wr_addr = 4'(i);
      wr_data = 8'($urandom_range(0, 255));
      step(a);
    end
    idle(3);
    checks++;
    if (bypass_count !== 16'hFFFF || bypass_model != 65535 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL bypass_saturation: byp=%h model=%0d left=%0d, expected ffff 65535 0",
               bypass_count, bypass_model, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_late_write();
    test_collision();
    test_backpressure();
    test_alternating();
    test_async_reset();
    test_bypass_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
